// File: rtl/sha256_msg_sched_if.sv
// Block-load and per-round stream bundle of the SHA-256 message scheduler.
// master = the scheduler itself, slave = the loader/compression environment.
interface sha256_msg_sched_if;
  logic        in_valid;
  logic [31:0] in_word;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_w;
  logic [31:0] out_k;
  logic [5:0]  out_round;
  logic        done;

  modport master (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_w, out_k, out_round, done
  );

  modport slave (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_w, out_k, out_round, done
  );
endinterface

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule / round-constant stream: loads 16 words, emits W[t], K[t], t.
// Define SHA_SCHED_BYTESWAP_EN to byte-reverse incoming words (little-endian host buses).
module sha256_msg_sched (
  input  logic               clk,
  input  logic               rst_n,
  sha256_msg_sched_if.master bus
);

  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_t      state;
  state_t      state_next;
  logic [3:0]  load_cnt;
  logic [5:0]  round;
  logic [31:0] window [16];
  logic        done_q;
  logic        take_word;
  logic        take_round;
  logic        in_ready_c;
  logic        out_valid_c;
  logic [31:0] next_word;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  function automatic logic [31:0] load_word(input logic [31:0] x);
`ifdef SHA_SCHED_BYTESWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  always_comb begin
    state_next  = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    take_word   = 1'b0;
    take_round  = 1'b0;
    if (state == LOAD) begin
      in_ready_c = 1'b1;
      take_word  = bus.in_valid;
      if (take_word && (load_cnt == 4'd15)) state_next = RUN;
    end else begin
      out_valid_c = 1'b1;
      take_round  = bus.out_ready;
      if (take_round && (round == 6'd63)) state_next = LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_next;
  end

  // W[t+16] from the sliding window; words produced past round 48 simply fall off.
  always_comb next_word = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt <= 4'd0;
      round    <= 6'd0;
      done_q   <= 1'b0;
      for (int i = 0; i < 16; i++) window[i] <= 32'd0;
    end else begin
      done_q <= take_round && (round == 6'd63);
      if (take_word) begin
        for (int i = 0; i < 15; i++) window[i] <= window[i+1];
        window[15] <= load_word(bus.in_word);
        load_cnt   <= load_cnt + 4'd1;
        round      <= 6'd0;
      end else if (take_round) begin
        for (int i = 0; i < 15; i++) window[i] <= window[i+1];
        window[15] <= next_word;
        round      <= round + 6'd1;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_w     = window[0];
  assign bus.out_k     = K_ROM[round];
  assign bus.out_round = round;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Bench for sha256_msg_sched: FIPS-style schedule model, per-cycle compare, directed scenarios.
// Build with SHA_SCHED_BYTESWAP_EN to drive the little-endian form of the same block.
module tb_sha256_msg_sched;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic clk;
  logic rst_n;
  sha256_msg_sched_if bus ();

  sha256_msg_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;

  // model state
  bit          m_mode;
  int          m_cnt;
  int          m_t;
  bit          m_done;
  logic [31:0] m_words [16];
  logic [31:0] m_w [64];

  logic [31:0] obs_w [64];
  logic [31:0] obs_k [64];
  logic [31:0] ref_w [64];
  int          done_cnt = 0;
  int          acc_cnt = 0;
  bit          prev_stall;
  logic [31:0] prev_w, prev_k;
  logic [5:0]  prev_r;

  int ready_mode = 0;
  int stall_left = 0;
  bit stalled = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ms0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ms1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // big-endian "abc" block as the hash sees it
  function automatic logic [31:0] std_word(input int i);
    if (i == 0)  return 32'h61626380;
    if (i == 15) return 32'h00000018;
    return 32'h0;
  endfunction

  function automatic logic [31:0] host_word(input logic [31:0] x);
`ifdef SHA_SCHED_BYTESWAP_EN
    return bswap(x);
`else
    return x;
`endif
  endfunction

  task automatic expand();
    for (int t = 0; t < 16; t++) m_w[t] = m_words[t];
    for (int t = 16; t < 64; t++)
      m_w[t] = ms1(m_w[t-2]) + m_w[t-7] + ms0(m_w[t-15]) + m_w[t-16];
  endtask

  // compare process: observe at the falling edge, then advance the model for the next rising edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_mode = 0; m_cnt = 0; m_t = 0; m_done = 0; prev_stall = 0;
      end else begin
        chk("in_ready", {31'b0, bus.in_ready}, {31'b0, !m_mode});
        chk("out_valid", {31'b0, bus.out_valid}, {31'b0, m_mode});
        chk("done", {31'b0, bus.done}, {31'b0, m_done});
        if (m_mode) begin
          chk("out_w", bus.out_w, m_w[m_t]);
          chk("out_k", bus.out_k, KT[m_t]);
          chk("out_round", {26'b0, bus.out_round}, m_t);
          obs_w[m_t] = bus.out_w;
          obs_k[m_t] = bus.out_k;
        end
        if (prev_stall && bus.out_valid) begin
          chk("stall_w", bus.out_w, prev_w);
          chk("stall_k", bus.out_k, prev_k);
          chk("stall_round", {26'b0, bus.out_round}, {26'b0, prev_r});
        end
        if (bus.done) done_cnt++;
        if (bus.in_valid && bus.in_ready) acc_cnt++;
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_w = bus.out_w; prev_k = bus.out_k; prev_r = bus.out_round;
        m_done = 0;
        if (!m_mode) begin
          if (bus.in_valid) begin
`ifdef SHA_SCHED_BYTESWAP_EN
            m_words[m_cnt] = bswap(bus.in_word);
`else
            m_words[m_cnt] = bus.in_word;
`endif
            m_cnt++;
            if (m_cnt == 16) begin
              expand();
              m_mode = 1; m_t = 0; m_cnt = 0;
            end
          end
        end else if (bus.out_ready) begin
          if (m_t == 63) begin
            m_mode = 0; m_done = 1;
          end else begin
            m_t++;
          end
        end
      end
    end
  end

  // consumer: tied ready, or random ready with a forced 5-cycle stall at round 20
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) begin
        bus.out_ready = 1'b1;
      end else begin
        if (!stalled && bus.out_valid && bus.out_round == 6'd20) begin
          stalled = 1; stall_left = 5;
        end
        if (stall_left > 0) begin
          bus.out_ready = 1'b0;
          stall_left--;
        end else begin
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  task automatic load_block(input bit gaps, input bit hold);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        bus.in_valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
      end
      bus.in_valid = 1'b1;
      bus.in_word  = host_word(std_word(i));
      @(posedge clk); #1;
    end
    if (hold) bus.in_word = 32'hdeadbeef;
    else      bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_cnt >= target) begin ok = 1; break; end
    end
    if (!ok) timeout(name);
  endtask

  task automatic wait_round(input int r, input int budget, input string name);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (bus.out_valid && bus.out_round == 6'(r)) begin ok = 1; break; end
    end
    if (!ok) timeout(name);
  endtask

  task automatic reset_pulse();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_round", {26'b0, bus.out_round}, 32'd0);
    chk("rst_out_w", bus.out_w, 32'd0);
    chk("rst_out_k", bus.out_k, 32'h428a2f98);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic clear_obs();
    for (int t = 0; t < 64; t++) begin obs_w[t] = 32'hx; obs_k[t] = 32'hx; end
  endtask

  task automatic compare_ref(input string name);
    for (int t = 0; t < 64; t++) chk(name, obs_w[t], ref_w[t]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got no end expected end");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_word = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset_pulse();

    // "abc" block, consumer always ready
    clear_obs();
    load_block(0, 0);
    wait_done(1, 200, "done_abc");
    for (int t = 0; t < 64; t++) ref_w[t] = obs_w[t];
    chk("abc_t0_w", obs_w[0], 32'h61626380);
    chk("abc_t0_k", obs_k[0], 32'h428a2f98);
    chk("abc_t15_w", obs_w[15], 32'h00000018);
    chk("abc_t16_w", obs_w[16], 32'h61626380);
    chk("abc_t17_w", obs_w[17], 32'h000f0000);
    chk("abc_t63_k", obs_k[63], 32'hc67178f2);
    chk("model_w17", m_w[17], 32'h000f0000);
    repeat (4) begin @(posedge clk); #1; end
    chk("abc_done_once", done_cnt, 32'd1);

    // backpressure
    clear_obs();
    ready_mode = 1;
    load_block(0, 0);
    wait_done(2, 2000, "done_bp");
    ready_mode = 0;
    chk("bp_stall_seen", {31'b0, stalled}, 32'd1);
    compare_ref("bp_w_seq");

    // input gaps, then in_valid held through RUN
    repeat (2) begin @(posedge clk); #1; end
    clear_obs();
    acc_cnt = 0;
    load_block(1, 1);
    wait_round(63, 200, "gap_round63");
    bus.in_valid = 1'b0;
    wait_done(3, 50, "done_gap");
    chk("gap_words_taken", acc_cnt, 32'd16);
    compare_ref("gap_w_seq");

    // reset in the middle of RUN, then a fresh block
    repeat (2) begin @(posedge clk); #1; end
    load_block(0, 0);
    wait_round(30, 100, "abort_round30");
    saved = done_cnt;
    reset_pulse();
    repeat (70) begin @(posedge clk); #1; end
    chk("abort_no_done", done_cnt, saved);
    clear_obs();
    load_block(0, 0);
    wait_done(saved + 1, 200, "done_after_rst");
    compare_ref("rst_w_seq");
    chk("rst_t0_w", obs_w[0], 32'h61626380);

    repeat (3) begin @(posedge clk); #1; end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
